// File: rtl/cbd_sampler_pkg.sv
// rtl/cbd_sampler_pkg.sv - shared constants and encodings for the CBD sampler
package cbd_sampler_pkg;

  localparam int Q         = 3329;
  localparam int N_COEF    = 256;
  localparam int Z_W       = 1536;
  localparam int COEF_W    = 12;
  localparam int ETA2_BITS = 1024;

  localparam logic [1:0] N_NUM_ETA3 = 2'd1;
  localparam logic [1:0] N_NUM_ETA2 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cbd_sampler_if.sv
// rtl/cbd_sampler_if.sv - request / coefficient stream bundle for the CBD sampler
interface cbd_sampler_if;

  logic                                    start;
  logic [1:0]                              n_num;
  logic [0:cbd_sampler_pkg::Z_W-1]         Z;
  logic                                    coef_ready;
  logic                                    coef_valid;
  logic [cbd_sampler_pkg::COEF_W-1:0]      coef;
  logic [7:0]                              coef_idx;
  logic                                    busy;
  logic                                    done;

  // Requester / consumer side
  modport master (
    output start, n_num, Z, coef_ready,
    input  coef_valid, coef, coef_idx, busy, done
  );

  // Sampler side
  modport slave (
    input  start, n_num, Z, coef_ready,
    output coef_valid, coef, coef_idx, busy, done
  );

endinterface

// File: rtl/cbd_sampler_coef.sv
// rtl/cbd_sampler_coef.sv - one CBD_eta coefficient from a 6-bit Kyber-ordered window
module cbd_coef
  import cbd_sampler_pkg::*;
(
  input  logic [5:0]        win,
  input  logic              eta3,
  output logic [COEF_W-1:0] coef
);

  logic [1:0] a;
  logic [1:0] b;

  // Popcount both halves, then fold a negative difference into [0, Q-1]
  always_comb begin
    a = {1'b0, win[0]} + {1'b0, win[1]} + {1'b0, eta3 & win[2]};
    if (eta3) begin
      b = {1'b0, win[3]} + {1'b0, win[4]} + {1'b0, win[5]};
    end else begin
      b = {1'b0, win[2]} + {1'b0, win[3]};
    end
    if (a >= b) begin
      coef = {{(COEF_W-2){1'b0}}, a - b};
    end else begin
      coef = COEF_W'(Q) - {{(COEF_W-2){1'b0}}, b - a};
    end
  end

endmodule

// File: rtl/cbd_sampler.sv
// rtl/cbd_sampler.sv - turns a PRF Z block into 256 CBD coefficients over valid/ready
module cbd_sampler
  import cbd_sampler_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  cbd_sampler_if.slave  bus
);

  state_e           state_q, state_d;
  logic [Z_W-1:0]   sr_q, sr_d;
  logic [7:0]       idx_q, idx_d;
  logic             eta3_q, eta3_d;

  logic [Z_W-1:0]   z_kyber;
  logic             start_ok;
  logic             hs;
  logic [COEF_W-1:0] coef_raw;

  assign start_ok = bus.start && (bus.n_num == N_NUM_ETA3 || bus.n_num == N_NUM_ETA2);
  assign hs       = (state_q == ST_RUN) && bus.coef_ready;

  // Reorder Z into Kyber bit order (bit 0 = LSB of byte 0); unused tail cleared for eta=2
  always_comb begin
    z_kyber = '0;
    for (int j = 0; j < Z_W / 8; j++) begin
      for (int k = 0; k < 8; k++) begin
        if (bus.n_num == N_NUM_ETA3 || (8 * j + k) < ETA2_BITS) begin
          z_kyber[8 * j + k] = bus.Z[8 * j + 7 - k];
        end
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      eta3_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      eta3_q  <= eta3_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN:  if (hs && idx_q == 8'd255) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch Z on accepted start, advance the window by 2*eta on each transfer
  always_comb begin
    sr_d   = sr_q;
    idx_d  = idx_q;
    eta3_d = eta3_q;
    if (state_q == ST_IDLE && start_ok) begin
      sr_d   = z_kyber;
      eta3_d = (bus.n_num == N_NUM_ETA3);
      idx_d  = '0;
    end else if (hs) begin
      sr_d  = eta3_q ? (sr_q >> 6) : (sr_q >> 4);
      idx_d = idx_q + 8'd1;
    end
  end

  cbd_coef u_coef (
    .win  (sr_q[5:0]),
    .eta3 (eta3_q),
    .coef (coef_raw)
  );

  // Outputs decoded from registered state only
  always_comb begin
    bus.coef_valid = (state_q == ST_RUN);
    bus.busy       = (state_q != ST_IDLE);
    bus.done       = (state_q == ST_DONE);
    bus.coef_idx   = idx_q;
    bus.coef       = (state_q == ST_RUN) ? coef_raw : '0;
  end

endmodule

// File: tb/tb_cbd_sampler.sv
// tb/tb_cbd_sampler.sv - directed vector bench for cbd_sampler
module tb_cbd_sampler;
  import cbd_sampler_pkg::*;

  logic clk;
  logic rst;
  cbd_sampler_if bus();

  cbd_sampler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_fail;
  logic [11:0] got [256];

  typedef struct {
    logic [1:0] nn;
    logic [7:0] b0;
    logic [7:0] b1;
    int         e0;
    int         e1;
    int         e2;
    int         e3;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_coef(input logic [0:Z_W-1] z, input int eta, input int i);
    int a, b, n;
    a = 0;
    b = 0;
    for (int k = 0; k < eta; k++) begin
      n = 2 * i * eta + k;
      a += int'(z[8 * (n / 8) + 7 - (n % 8)]);
      n = 2 * i * eta + eta + k;
      b += int'(z[8 * (n / 8) + 7 - (n % 8)]);
    end
    return (a >= b) ? (a - b) : (Q - (b - a));
  endfunction

  task automatic do_start(input logic [1:0] nn, input logic [0:Z_W-1] z);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.n_num = nn;
    bus.Z     = z;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run(input logic [1:0] nn, input logic [0:Z_W-1] z, input bit rnd, input int inj_at);
    int cnt, cyc, stall, eta, r;
    eta   = (nn == N_NUM_ETA3) ? 3 : 2;
    cnt   = 0;
    cyc   = 0;
    stall = 0;
    bus.coef_ready = 1'b1;
    do_start(nn, z);
    while (cnt < 256 && cyc < 3000) begin
      @(negedge clk);
      chk("valid", int'(bus.coef_valid), 1);
      if (bus.coef_valid !== 1'b1) break;
      chk("idx", int'(bus.coef_idx), cnt);
      chk("coef", int'(bus.coef), ref_coef(z, eta, cnt));
      if (bus.coef_ready) begin
        got[cnt] = bus.coef;
        cnt++;
      end
      cyc++;
      @(posedge clk); #1;
      bus.start = (cyc == inj_at);
      if (cyc == inj_at) begin
        bus.n_num = N_NUM_ETA3;
        bus.Z     = ~z;
      end
      if (rnd) begin
        if (stall > 0) begin
          bus.coef_ready = 1'b0;
          stall--;
        end else begin
          r = int'($urandom_range(0, 9));
          if (r == 0) begin
            bus.coef_ready = 1'b0;
            stall = 4;
          end else begin
            bus.coef_ready = (r > 3);
          end
        end
      end
    end
    bus.start = 1'b0;
    chk("handshakes", cnt, 256);
    if (!rnd) chk("run_cycles", cyc, 256);
    @(negedge clk);
    chk("done_pulse", int'(bus.done), 1);
    chk("done_valid", int'(bus.coef_valid), 0);
    chk("done_busy", int'(bus.busy), 1);
    @(negedge clk);
    chk("after_done", int'(bus.done), 0);
    chk("after_busy", int'(bus.busy), 0);
    bus.coef_ready = 1'b1;
  endtask

  initial begin
    logic [0:Z_W-1] z;
    n_vec  = 0;
    n_fail = 0;

    vt[0] = '{2'd1, 8'h00, 8'h00, 0,    0, 0, 0};
    vt[1] = '{2'd2, 8'h03, 8'h30, 2,    0, 0, 2};
    vt[2] = '{2'd2, 8'h03, 8'hC0, 2,    0, 0, 3327};
    vt[3] = '{2'd1, 8'h38, 8'h00, 3326, 0, 0, 0};
    vt[4] = '{2'd1, 8'h07, 8'h00, 3,    0, 0, 0};

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.n_num      = 2'd0;
    bus.Z          = '0;
    bus.coef_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(bus.coef_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_idx", int'(bus.coef_idx), 0);
    chk("rst_coef", int'(bus.coef), 0);

    // Table vectors: full-rate runs with hand-computed leading coefficients
    for (int v = 0; v < 5; v++) begin
      z = '0;
      z[0:7]  = vt[v].b0;
      z[8:15] = vt[v].b1;
      run(vt[v].nn, z, 1'b0, -1);
      chk("tab_c0", int'(got[0]), vt[v].e0);
      chk("tab_c1", int'(got[1]), vt[v].e1);
      chk("tab_c2", int'(got[2]), vt[v].e2);
      chk("tab_c3", int'(got[3]), vt[v].e3);
    end

    // Invalid eta selects are ignored
    for (int nn = 0; nn < 4; nn += 3) begin
      do_start(2'(nn), '1);
      @(negedge clk);
      chk("bad_nnum_busy", int'(bus.busy), 0);
      chk("bad_nnum_valid", int'(bus.coef_valid), 0);
    end

    // Random Z, eta=2, random backpressure with long stalls
    for (int i = 0; i < Z_W / 32; i++) z[32 * i +: 32] = $urandom;
    run(N_NUM_ETA2, z, 1'b1, -1);

    // Random Z, eta=3, start pulse plus Z change mid-run
    for (int i = 0; i < Z_W / 32; i++) z[32 * i +: 32] = $urandom;
    run(N_NUM_ETA3, z, 1'b0, 40);

    // Reset after 100 transfers
    for (int i = 0; i < Z_W / 32; i++) z[32 * i +: 32] = $urandom;
    do_start(N_NUM_ETA2, z);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(bus.coef_valid), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_idx", int'(bus.coef_idx), 0);
    chk("mid_rst_coef", int'(bus.coef), 0);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_no_done", int'(bus.done), 0);
      @(negedge clk);
    end
    for (int i = 0; i < Z_W / 32; i++) z[32 * i +: 32] = $urandom;
    run(N_NUM_ETA2, z, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
